// File: rtl/align_ctrl.sv
// align_ctrl: word-alignment controller for a deserializing receiver.
// It watches comparator results and issues bitslip pulses until CHECK
// consecutive matching words are seen, then holds lock. While locked it
// tracks errors, and it realigns after ERR_LIMIT consecutive mismatches.
// It gives up (O_FAIL) after 2*WIDTH slips without reaching lock.
//
// Ports:
//   CLK        - sole clock, rising edge
//   RST        - asynchronous active-high reset
//   I_START    - level request to begin/restart alignment (IDLE/FAIL only)
//   I_VALID    - comparator strobe qualifying I_MATCH
//   I_MATCH    - 1 = received word equals expected word
//   O_BITSLIP  - one-cycle bitslip pulse to the deserializer
//   O_LOCKED   - alignment achieved and held
//   O_FAIL     - alignment abandoned after the try limit
//   O_SLIP_CNT - bitslips since last start, modulo WIDTH
//   O_ERR_CNT  - mismatches seen while locked, saturating
module align_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned CHECK     = 16,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_START,
  input  logic        I_VALID,
  input  logic        I_MATCH,
  output logic        O_BITSLIP,
  output logic        O_LOCKED,
  output logic        O_FAIL,
  output logic [3:0]  O_SLIP_CNT,
  output logic [15:0] O_ERR_CNT
);

  localparam int unsigned MRW = $clog2(CHECK + 1);
  localparam int unsigned ERW = $clog2(ERR_LIMIT + 1);
  localparam int unsigned STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned TRW = $clog2(2 * WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [MRW-1:0]   match_run_q, match_run_d;
  logic [ERW-1:0]   err_run_q, err_run_d;
  logic [STW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TRW-1:0]   tries_q, tries_d;
  logic [3:0]       slip_cnt_q, slip_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             bitslip_q, bitslip_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  always_comb begin
    state_d      = state_q;
    match_run_d  = match_run_q;
    err_run_d    = err_run_q;
    settle_cnt_d = settle_cnt_q;
    tries_d      = tries_q;
    slip_cnt_d   = slip_cnt_q;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (I_START) begin
          slip_cnt_d  = '0;
          tries_d     = '0;
          match_run_d = '0;
          err_run_d   = '0;
          err_cnt_d   = '0;
          state_d     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (I_VALID) begin
          // A mismatch always wins; the lock test only runs on a match.
          if (!I_MATCH) begin
            match_run_d = '0;
            if (tries_q < TRW'(2 * WIDTH)) begin
              state_d = ST_SLIP;
            end else begin
              state_d = ST_FAIL;
            end
          end else if (match_run_q == MRW'(CHECK - 1)) begin
            match_run_d = MRW'(CHECK);
            state_d     = ST_LOCKED;
          end else begin
            match_run_d = match_run_q + 1'b1;
          end
        end
      end

      ST_SLIP: begin
        slip_cnt_d   = (slip_cnt_q == 4'(WIDTH - 1)) ? '0 : slip_cnt_q + 4'd1;
        tries_d      = tries_q + 1'b1;
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_q == STW'(SETTLE - 1)) begin
          match_run_d = '0;
          state_d     = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      ST_LOCKED: begin
        if (I_VALID) begin
          if (!I_MATCH) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_run_q == ERW'(ERR_LIMIT - 1)) begin
              // Realignment restarts the try budget; the error total is kept.
              err_run_d = '0;
              tries_d   = '0;
              state_d   = ST_SLIP;
            end else begin
              err_run_d = err_run_q + 1'b1;
            end
          end else begin
            err_run_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so they are registered and line
  // up exactly with the state they describe.
  always_comb begin
    bitslip_d = (state_d == ST_SLIP);
    locked_d  = (state_d == ST_LOCKED);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      match_run_q  <= '0;
      err_run_q    <= '0;
      settle_cnt_q <= '0;
      tries_q      <= '0;
      slip_cnt_q   <= '0;
      err_cnt_q    <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_run_q  <= match_run_d;
      err_run_q    <= err_run_d;
      settle_cnt_q <= settle_cnt_d;
      tries_q      <= tries_d;
      slip_cnt_q   <= slip_cnt_d;
      err_cnt_q    <= err_cnt_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign O_BITSLIP  = bitslip_q;
  assign O_LOCKED   = locked_q;
  assign O_FAIL     = fail_q;
  assign O_SLIP_CNT = slip_cnt_q;
  assign O_ERR_CNT  = err_cnt_q;

endmodule
